minefield_sequencer: RTL and testbench

- Controls the 8x8 Buscaminas board storage.
- On start, it seeds an LFSR, places NUM_MINES unique mines, then sweeps all 64 cells to compute neighbour counts.
- It then serves player reveal requests over a valid/ready handshake, tracks revealed cells and flags loss or win.
- It sits between the input/FSM logic (keys, cursor) and the VGA/display path, which reads mine_map, revealed and the reveal responses.

---
 rtl/minefield_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_minefield_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minefield_sequencer.sv
// Minefield sequencer for an 8x8 board: seeds an LFSR, places unique mines,
// sweeps the board to build neighbour counts, then answers reveal requests
// and tracks win/loss.
module minefield_sequencer #(
    parameter int         NUM_MINES    = 10,
    parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        busy,
    output logic        ready_game,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_row,
    input  logic [2:0]  req_col,
    output logic        resp_valid,
    output logic        resp_mine,
    output logic [3:0]  resp_count,
    output logic [63:0] mine_map,
    output logic [63:0] revealed,
    output logic        game_over,
    output logic        game_won
);

    localparam logic [5:0] MINES_W = 6'(NUM_MINES);
    localparam logic [6:0] WIN_TGT = 7'(64 - NUM_MINES);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PLACE, S_COUNT, S_PLAY, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  seed_q;
    logic [7:0]  lfsr_q;
    logic [5:0]  placed_q;
    logic [5:0]  cidx_q;
    logic [6:0]  tally_q;
    logic [63:0] mine_map_q;
    logic [63:0] revealed_q;
    logic [3:0]  counts_q [64];
    logic        resp_valid_q;
    logic        resp_mine_q;
    logic [3:0]  resp_count_q;
    logic        game_over_q;
    logic        game_won_q;

    logic        start_ok;
    logic        xfer;
    logic [5:0]  req_idx;
    logic [7:0]  lfsr_step;
    logic [5:0]  cand;
    logic        cand_new;
    logic        last_mine;
    logic        req_mine;
    logic        req_new;
    logic        win_hit;
    logic [7:0]  seed_eff;

    // Number of mines among the up-to-8 on-board neighbours of a cell.
    function automatic logic [3:0] nbr_count(input logic [63:0] m, input logic [5:0] idx);
        logic [3:0] n;
        int r, c, nr, nc;
        n = '0;
        r = int'(idx[5:3]);
        c = int'(idx[2:0]);
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = r + dr;
                nc = c + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < 8 && nc >= 0 && nc < 8)
                    n = n + {3'b000, m[6'(nr * 8 + nc)]};
            end
        end
        return n;
    endfunction

    // Decode of handshakes, LFSR step and placement/reveal events.
    always_comb begin
        start_ok  = start && (state_q == S_IDLE || state_q == S_PLAY || state_q == S_OVER);
        xfer      = (state_q == S_PLAY) && req_valid && !start;
        req_idx   = {req_row, req_col};
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand      = lfsr_step[5:0];
        cand_new  = !mine_map_q[cand];
        last_mine = (state_q == S_PLACE) && cand_new && (placed_q == MINES_W - 6'd1);
        req_mine  = mine_map_q[req_idx];
        req_new   = !revealed_q[req_idx];
        win_hit   = xfer && !req_mine && req_new && (tally_q == WIN_TGT - 7'd1);
        if (seed_q != 8'h00)
            seed_eff = seed_q;
        else if (DEFAULT_SEED != 8'h00)
            seed_eff = DEFAULT_SEED;
        else
            seed_eff = 8'h01;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        ready_game = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                busy    = 1'b1;
                state_d = S_PLACE;
            end
            S_PLACE: begin
                busy = 1'b1;
                if (last_mine) state_d = S_COUNT;
            end
            S_COUNT: begin
                busy = 1'b1;
                if (cidx_q == 6'd63) state_d = S_PLAY;
            end
            S_PLAY: begin
                ready_game = 1'b1;
                req_ready  = 1'b1;
                if (start)
                    state_d = S_CLEAR;
                else if (xfer && (req_mine || win_hit))
                    state_d = S_OVER;
            end
            S_OVER: begin
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Board storage, LFSR, counters and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q       <= '0;
            lfsr_q       <= 8'h01;
            placed_q     <= '0;
            cidx_q       <= '0;
            tally_q      <= '0;
            mine_map_q   <= '0;
            revealed_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_mine_q  <= 1'b0;
            resp_count_q <= '0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
            for (int k = 0; k < 64; k++) counts_q[k] <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (start_ok) seed_q <= seed;
            case (state_q)
                S_CLEAR: begin
                    mine_map_q  <= '0;
                    revealed_q  <= '0;
                    game_over_q <= 1'b0;
                    game_won_q  <= 1'b0;
                    placed_q    <= '0;
                    cidx_q      <= '0;
                    tally_q     <= '0;
                    lfsr_q      <= seed_eff;
                    for (int k = 0; k < 64; k++) counts_q[k] <= '0;
                end
                S_PLACE: begin
                    lfsr_q <= lfsr_step;
                    if (cand_new) begin
                        mine_map_q[cand] <= 1'b1;
                        placed_q         <= placed_q + 6'd1;
                    end
                    if (last_mine) cidx_q <= '0;
                end
                S_COUNT: begin
                    counts_q[cidx_q] <= nbr_count(mine_map_q, cidx_q);
                    cidx_q           <= cidx_q + 6'd1;
                end
                S_PLAY: begin
                    if (xfer) begin
                        resp_valid_q        <= 1'b1;
                        resp_mine_q         <= req_mine;
                        resp_count_q        <= counts_q[req_idx];
                        revealed_q[req_idx] <= 1'b1;
                        if (req_mine)
                            game_over_q <= 1'b1;
                        else if (req_new)
                            tally_q <= tally_q + 7'd1;
                        if (win_hit) game_won_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_mine  = resp_mine_q;
    assign resp_count = resp_count_q;
    assign mine_map   = mine_map_q;
    assign revealed   = revealed_q;
    assign game_over  = game_over_q;
    assign game_won   = game_won_q;

endmodule

// File: tb/tb_minefield_sequencer.sv
// Bench for minefield_sequencer: two instances (1 mine and 10 mines) checked
// against a board-level model plus hand-computed literals.
module tb_minefield_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st   [2];
    logic [7:0]  sd   [2];
    logic        rv   [2];
    logic [2:0]  rr   [2];
    logic [2:0]  rc   [2];
    logic        busy [2];
    logic        rg   [2];
    logic        rdy  [2];
    logic        vld  [2];
    logic        rmine[2];
    logic [3:0]  rcnt [2];
    logic [63:0] mm   [2];
    logic [63:0] rev  [2];
    logic        ov   [2];
    logic        won  [2];

    minefield_sequencer #(.NUM_MINES(1), .DEFAULT_SEED(8'hA5)) u0 (
        .clk(clk), .reset(rst), .start(st[0]), .seed(sd[0]), .busy(busy[0]),
        .ready_game(rg[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_row(rr[0]),
        .req_col(rc[0]), .resp_valid(vld[0]), .resp_mine(rmine[0]), .resp_count(rcnt[0]),
        .mine_map(mm[0]), .revealed(rev[0]), .game_over(ov[0]), .game_won(won[0]));

    minefield_sequencer #(.NUM_MINES(10), .DEFAULT_SEED(8'hA5)) u1 (
        .clk(clk), .reset(rst), .start(st[1]), .seed(sd[1]), .busy(busy[1]),
        .ready_game(rg[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_row(rr[1]),
        .req_col(rc[1]), .resp_valid(vld[1]), .resp_mine(rmine[1]), .resp_count(rcnt[1]),
        .mine_map(mm[1]), .revealed(rev[1]), .game_over(ov[1]), .game_won(won[1]));

    int errors = 0;
    int checks = 0;

    // Board model
    int          nmines [2] = '{1, 10};
    logic [63:0] m_map  [2];
    logic [63:0] m_rev  [2];
    int          m_cnt  [2][64];
    bit          m_active[2];
    bit          m_over [2];
    bit          m_won  [2];
    int          m_tally[2];
    int          m_attempts[2];
    int          q0[$];
    int          q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic build(input int i, input logic [7:0] seed);
        logic [7:0] s;
        int placed, n, ar, ac;
        s = (seed == 8'h00) ? 8'hA5 : seed;
        m_map[i] = '0; m_rev[i] = '0; m_over[i] = 0; m_won[i] = 0;
        m_tally[i] = 0; m_attempts[i] = 0; placed = 0;
        while (placed < nmines[i]) begin
            s = lfsr_next(s);
            m_attempts[i]++;
            if (!m_map[i][s[5:0]]) begin
                m_map[i][s[5:0]] = 1'b1;
                placed++;
            end
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        ar = r + dr; ac = c + dc;
                        if ((dr != 0 || dc != 0) && ar >= 0 && ar < 8 && ac >= 0 && ac < 8)
                            if (m_map[i][6'(ar * 8 + ac)]) n++;
                    end
                end
                m_cnt[i][r * 8 + c] = n;
            end
        end
    endtask

    // Accepted requests update the model and queue the expected response.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && m_active[i] && rv[i] && !st[i] && !m_over[i] && !m_won[i]) begin
                int idx, e;
                bit mine;
                idx  = int'(rr[i]) * 8 + int'(rc[i]);
                mine = m_map[i][6'(idx)];
                e    = (mine ? 16 : 0) + m_cnt[i][idx];
                if (i == 0) q0.push_back(e); else q1.push_back(e);
                if (mine) m_over[i] = 1;
                else if (!m_rev[i][6'(idx)]) begin
                    m_tally[i]++;
                    if (m_tally[i] == 64 - nmines[i]) m_won[i] = 1;
                end
                m_rev[i][6'(idx)] = 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_active[i]) begin
                bit has;
                int e;
                chk($sformatf("u%0d mine_map", i), mm[i], m_map[i]);
                chk($sformatf("u%0d revealed", i), rev[i], m_rev[i]);
                chk($sformatf("u%0d game_over", i), 64'(ov[i]), 64'(m_over[i]));
                chk($sformatf("u%0d game_won", i), 64'(won[i]), 64'(m_won[i]));
                chk($sformatf("u%0d req_ready", i), 64'(rdy[i]), 64'(!(m_over[i] || m_won[i])));
                chk($sformatf("u%0d ready_game", i), 64'(rg[i]), 64'(!(m_over[i] || m_won[i])));
                chk($sformatf("u%0d busy", i), 64'(busy[i]), 64'd0);
                has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                chk($sformatf("u%0d resp_valid", i), 64'(vld[i]), 64'(has));
                if (has) begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d resp_mine", i), 64'(rmine[i]), 64'(e / 16));
                    chk($sformatf("u%0d resp_count", i), 64'(rcnt[i]), 64'(e % 16));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int i);
        chk($sformatf("u%0d rst busy", i), 64'(busy[i]), 64'd0);
        chk($sformatf("u%0d rst ready_game", i), 64'(rg[i]), 64'd0);
        chk($sformatf("u%0d rst req_ready", i), 64'(rdy[i]), 64'd0);
        chk($sformatf("u%0d rst resp_valid", i), 64'(vld[i]), 64'd0);
        chk($sformatf("u%0d rst resp_mine", i), 64'(rmine[i]), 64'd0);
        chk($sformatf("u%0d rst resp_count", i), 64'(rcnt[i]), 64'd0);
        chk($sformatf("u%0d rst mine_map", i), mm[i], 64'd0);
        chk($sformatf("u%0d rst revealed", i), rev[i], 64'd0);
        chk($sformatf("u%0d rst game_over", i), 64'(ov[i]), 64'd0);
        chk($sformatf("u%0d rst game_won", i), 64'(won[i]), 64'd0);
    endtask

    // Start a game; optionally pulse start again mid-COUNT (must be ignored).
    task automatic start_game(input int i, input logic [7:0] seed, input bit poke, output int bcyc);
        int t;
        st[i] = 1'b1; sd[i] = seed;
        tick();
        st[i] = 1'b0; rv[i] = 1'b0; m_active[i] = 0;
        chk($sformatf("u%0d resp after start", i), 64'(vld[i]), 64'd0);
        build(i, seed);
        bcyc = 0; t = 0;
        while (!rg[i] && t < 600) begin
            if (busy[i]) bcyc++;
            st[i] = (poke && bcyc == m_attempts[i] + 10) ? 1'b1 : 1'b0;
            tick();
            t++;
        end
        st[i] = 1'b0;
        if (!rg[i]) begin
            checks++; errors++;
            $display("FAIL u%0d ready_game timeout: got 0 expected 1", i);
        end
        chk($sformatf("u%0d busy cycles", i), 64'(bcyc), 64'(1 + m_attempts[i] + 64));
        m_active[i] = 1;
    endtask

    task automatic reveal_burst(input int i, input int cells[$]);
        foreach (cells[k]) begin
            rr[i] = 3'(cells[k] / 8);
            rc[i] = 3'(cells[k] % 8);
            rv[i] = 1'b1;
            tick();
        end
        rv[i] = 1'b0;
    endtask

    initial begin
        int b;
        int cells[$];
        int last;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; sd[i] = 0; rv[i] = 0; rr[i] = 0; rc[i] = 0; m_active[i] = 0;
        end
        tick(); tick();
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        tick();

        // Reset in the middle of mine placement
        st[1] = 1'b1; sd[1] = 8'h00;
        tick();
        st[1] = 1'b0;
        tick(); tick();
        chk("u1 busy in PLACE", 64'(busy[1]), 64'd1);
        chk("u1 first mine", mm[1], 64'h400);
        rst = 1'b1;
        tick();
        chk_zero(1);
        rst = 1'b0;
        tick();

        // One mine, seed 1: mine at index 2
        start_game(0, 8'h01, 0, b);
        chk("u0 busy 66", 64'(b), 64'd66);
        chk("u0 map literal", mm[0], 64'h4);
        chk("model cnt(0,1)", 64'(m_cnt[0][1]), 64'd1);
        chk("model cnt(1,3)", 64'(m_cnt[0][11]), 64'd1);
        chk("model cnt(7,7)", 64'(m_cnt[0][63]), 64'd0);
        reveal_burst(0, '{1, 3, 9, 10, 11});
        chk("u0 burst last count", 64'(rcnt[0]), 64'd1);
        chk("u0 burst last mine", 64'(rmine[0]), 64'd0);
        reveal_burst(0, '{63});
        chk("u0 (7,7) valid", 64'(vld[0]), 64'd1);
        chk("u0 (7,7) count", 64'(rcnt[0]), 64'd0);

        // start coincident with a request: start wins
        rv[0] = 1'b1; rr[0] = 3'd0; rc[0] = 3'd5;
        start_game(0, 8'h01, 0, b);
        chk("u0 coincident no reveal", rev[0], 64'd0);

        // Reveal the mine
        reveal_burst(0, '{2});
        chk("u0 mine resp", 64'(rmine[0]), 64'd1);
        chk("u0 game_over", 64'(ov[0]), 64'd1);
        chk("u0 req_ready after loss", 64'(rdy[0]), 64'd0);
        rv[0] = 1'b1; rr[0] = 3'd0; rc[0] = 3'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("u0 no resp in OVER", 64'(vld[0]), 64'd0);
        end
        rv[0] = 1'b0;

        // Win: all 63 safe cells, with a repeat
        start_game(0, 8'h01, 0, b);
        cells = {};
        for (int k = 0; k < 64; k++) begin
            if (k != 2) cells.push_back(k);
            if (k == 0) cells.push_back(0);
        end
        last = cells.pop_back();
        reveal_burst(0, cells);
        tick();
        chk("u0 not won yet", 64'(won[0]), 64'd0);
        chk("u0 revealed 62", rev[0], ~(64'h4 | 64'h8000_0000_0000_0000));
        reveal_burst(0, '{last});
        chk("u0 won", 64'(won[0]), 64'd1);
        chk("u0 revealed 63", rev[0], ~64'h4);
        chk("u0 not over", 64'(ov[0]), 64'd0);
        tick();

        // Ten mines, seed 0 -> default seed; start during COUNT ignored
        start_game(1, 8'h00, 1, b);
        chk("u1 busy 75", 64'(b), 64'd75);
        chk("u1 map literal", mm[1], 64'h0800_0680_2038_4400);
        chk("u1 popcount", 64'($countones(mm[1])), 64'd10);
        chk("model cnt(2,4)", 64'(m_cnt[1][20]), 64'd3);
        cells = {};
        for (int k = 0; k < 64; k++) if (!m_map[1][6'(k)]) cells.push_back(k);
        reveal_burst(1, cells);
        chk("u1 won", 64'(won[1]), 64'd1);
        tick();

        // Each mine cell in turn, alternating seed 0 / A5
        cells = {};
        for (int k = 0; k < 64; k++) if (m_map[1][6'(k)]) cells.push_back(k);
        foreach (cells[j]) begin
            start_game(1, (j % 2 == 0) ? 8'hA5 : 8'h00, 0, b);
            chk("u1 map same", mm[1], 64'h0800_0680_2038_4400);
            reveal_burst(1, '{cells[j]});
            chk("u1 mine over", 64'(ov[1]), 64'd1);
            tick();
        end

        tick();
        m_active[0] = 0; m_active[1] = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
